// File: rtl/i2c_pkg.sv
// Shared constants, state encoding and helpers for the EEPROM write sequencer.
// Bit-task command codes match the bit-level I2C controller interface.
package i2c_pkg;

   localparam logic [1:0] COM_ZERO  = 2'b00;
   localparam logic [1:0] COM_ONE   = 2'b11;
   localparam logic [1:0] COM_START = 2'b10;
   localparam logic [1:0] COM_STOP  = 2'b01;

   localparam int STEP_W = 5;

   localparam logic [STEP_W-1:0] LAST_STEP   = 5'd28;
   localparam logic [STEP_W-1:0] ACK_STEP_B0 = 5'd9;
   localparam logic [STEP_W-1:0] ACK_STEP_B1 = 5'd18;
   localparam logic [STEP_W-1:0] ACK_STEP_B2 = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RELEASE,
      ST_FINISH
   } state_t;

   function automatic logic [1:0] bit_com(input logic b);
      return b ? COM_ONE : COM_ZERO;
   endfunction

endpackage

// File: rtl/i2c_step_decode.sv
// Maps a frame step index plus the three latched frame bytes to a bit-task
// command: START, 8 MSB-first data bits per byte with an ACK slot after each, STOP.
module i2c_step_decode
   import i2c_pkg::*;
(
   input  logic [STEP_W-1:0] i_step,
   input  logic [7:0]        i_b0,
   input  logic [7:0]        i_b1,
   input  logic [7:0]        i_b2,
   output logic [1:0]        o_com
);

   logic [2:0] w_idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      w_idx = '0;
      o_com = COM_STOP;
      if (i_step == '0) begin
         o_com = COM_START;
      end else if (i_step < ACK_STEP_B0) begin
         w_idx = 3'(ACK_STEP_B0 - 5'd1 - i_step);
         o_com = bit_com(i_b0[w_idx]);
      end else if (i_step == ACK_STEP_B0) begin
         o_com = COM_ONE;
      end else if (i_step < ACK_STEP_B1) begin
         w_idx = 3'(ACK_STEP_B1 - 5'd1 - i_step);
         o_com = bit_com(i_b1[w_idx]);
      end else if (i_step == ACK_STEP_B1) begin
         o_com = COM_ONE;
      end else if (i_step < ACK_STEP_B2) begin
         w_idx = 3'(ACK_STEP_B2 - 5'd1 - i_step);
         o_com = bit_com(i_b2[w_idx]);
      end else if (i_step == ACK_STEP_B2) begin
         o_com = COM_ONE;
      end
   end

endmodule

// File: rtl/eeprom_write_sequencer.sv
// Transaction-level I2C master: issues the 29 bit-tasks of one EEPROM byte write
// to the bit-level controller over a com/en/done handshake, with a per-task watchdog.
module eeprom_write_sequencer
   import i2c_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [6:0] i_dev_addr,
   input  logic [7:0] i_mem_addr,
   input  logic [7:0] i_wr_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output logic [1:0] o_task_com,
   output logic       o_task_en,
   input  logic       i_task_done
);

   localparam logic [CNT_W-1:0] WD_LIMIT =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t            r_state;
   logic [STEP_W-1:0] r_step;
   logic [7:0]        r_b0;
   logic [7:0]        r_b1;
   logic [7:0]        r_b2;
   logic [CNT_W-1:0]  r_wdog;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic              r_task_en;
   logic [1:0]        r_task_com;

   logic [STEP_W-1:0] w_dec_step;
   logic [1:0]        w_next_com;
   logic              w_timeout;

   // Decode the command of the task about to be issued so task_com is loaded
   // on the same edge that raises task_en.
   assign w_dec_step = (r_state == ST_IDLE) ? '0 : r_step + STEP_W'(1);
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_LIMIT);

   i2c_step_decode u_step_decode (
      .i_step (w_dec_step),
      .i_b0   (r_b0),
      .i_b1   (r_b1),
      .i_b2   (r_b2),
      .o_com  (w_next_com)
   );

   // NOTE: the frame bytes are pure data qualified by the FSM, so they carry no reset.
   always_ff @(posedge i_clk) begin
      if (r_state == ST_IDLE && i_start) begin
         r_b0 <= {i_dev_addr, 1'b0};
         r_b1 <= i_mem_addr;
         r_b2 <= i_wr_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_step     <= '0;
         r_wdog     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_task_en  <= 1'b0;
         r_task_com <= COM_ZERO;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_step     <= '0;
                  r_wdog     <= '0;
                  r_task_com <= w_next_com;
                  r_task_en  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (i_task_done) begin
                  r_task_en <= 1'b0;
                  r_wdog    <= '0;
                  r_state   <= ST_RELEASE;
               end else if (w_timeout) begin
                  r_task_en <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_wdog    <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_wdog <= r_wdog + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               // Waiting for task_done to fall keeps task_en from rising on a stale done.
               if (!i_task_done) begin
                  r_wdog <= '0;
                  if (r_step == LAST_STEP) begin
                     r_busy  <= 1'b0;
                     r_state <= ST_FINISH;
                  end else begin
                     r_step     <= r_step + STEP_W'(1);
                     r_task_com <= w_next_com;
                     r_task_en  <= 1'b1;
                     r_state    <= ST_ISSUE;
                  end
               end else if (w_timeout) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_wdog  <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_wdog <= r_wdog + CNT_W'(1);
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_task_en  = r_task_en;
   assign o_task_com = r_task_com;

endmodule

// File: tb/tb_eeprom_write_sequencer.sv
// Directed bench for eeprom_write_sequencer: frame content, handshake order,
// start-while-busy, mid-frame reset, back-to-back and watchdog behaviour.
module tb_eeprom_write_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] dev;
   logic [7:0] mem;
   logic [7:0] dat;
   logic       busy, done, err, task_en, task_done;
   logic [1:0] task_com;

   logic       wd_start, wd_busy, wd_done, wd_err, wd_en, wd_td;
   logic [1:0] wd_com;
   logic       nw_start, nw_busy, nw_done, nw_err, nw_en, nw_td;
   logic [1:0] nw_com;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   eeprom_write_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_dev_addr(dev), .i_mem_addr(mem), .i_wr_data(dat),
      .o_busy(busy), .o_done(done), .o_err(err),
      .o_task_com(task_com), .o_task_en(task_en), .i_task_done(task_done)
   );

   eeprom_write_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut_wd (
      .i_clk(clk), .i_rst(rst), .i_start(wd_start),
      .i_dev_addr(dev), .i_mem_addr(mem), .i_wr_data(dat),
      .o_busy(wd_busy), .o_done(wd_done), .o_err(wd_err),
      .o_task_com(wd_com), .o_task_en(wd_en), .i_task_done(wd_td)
   );

   eeprom_write_sequencer #(.TIMEOUT_CYCLES(0), .CNT_W(8)) dut_nw (
      .i_clk(clk), .i_rst(rst), .i_start(nw_start),
      .i_dev_addr(dev), .i_mem_addr(mem), .i_wr_data(dat),
      .o_busy(nw_busy), .o_done(nw_done), .o_err(nw_err),
      .o_task_com(nw_com), .o_task_en(nw_en), .i_task_done(nw_td)
   );

   // Responder: raises task_done k cycles after task_en, drops it once task_en falls.
   int rsp_k   = 5;
   int rsp_cnt = 0;
   initial begin
      task_done = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            task_done = 1'b0;
            rsp_cnt   = 0;
         end else if (task_en && !task_done) begin
            rsp_cnt++;
            if (rsp_cnt >= rsp_k) begin
               task_done = 1'b1;
               rsp_cnt   = 0;
            end
         end else if (!task_en && task_done) begin
            task_done = 1'b0;
         end
      end
   end

   // Monitor: records the command of every issued task and counts handshake violations.
   logic [1:0] q[$];
   int         done_cnt = 0;
   int         err_cnt  = 0;
   int         viol     = 0;
   logic       p_en     = 1'b0;
   logic       p_td     = 1'b0;
   logic [1:0] p_com    = 2'b00;
   always @(negedge clk) begin
      if (task_en && p_en && task_com !== p_com) viol++;
      if (task_en && !p_en && p_td) viol++;
      if (task_en && !p_en) q.push_back(task_com);
      if (done) done_cnt++;
      if (err) err_cnt++;
      p_en  = task_en;
      p_td  = task_done;
      p_com = task_com;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c = 0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({tag, " done_seen"}, done, 1'b1);
   endtask

   task automatic clear_mon();
      q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      viol     = 0;
   endtask

   task automatic get_frame(input int base, output logic [63:0] f);
      f = '0;
      for (int i = 0; i < 29; i++)
         f = {f[61:0], (base + i < q.size()) ? q[base + i] : 2'bxx};
   endtask

   // Expected 29-task command stream, packed two bits per task, START first.
   function automatic logic [63:0] frame(input logic [6:0] d, input logic [7:0] m,
                                          input logic [7:0] w);
      logic [7:0]  b [3];
      logic [63:0] f;
      b[0] = {d, 1'b0};
      b[1] = m;
      b[2] = w;
      f = 64'h2;
      for (int j = 0; j < 3; j++) begin
         for (int i = 7; i >= 0; i--) f = {f[61:0], b[j][i] ? 2'b11 : 2'b00};
         f = {f[61:0], 2'b11};
      end
      f = {f[61:0], 2'b01};
      return f;
   endfunction

   task automatic run_frame(input string tag, input int k, input logic [6:0] d,
                            input logic [7:0] m, input logic [7:0] w,
                            input logic [63:0] exp);
      logic [63:0] f;
      rsp_k = k;
      clear_mon();
      dev   = d;
      mem   = m;
      dat   = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy_after_start"}, busy, 1'b1);
      wait_done(tag, 29 * (k + 6) + 20);
      check({tag, " err_at_done"}, err, 1'b0);
      check({tag, " busy_at_done"}, busy, 1'b0);
      tick(3);
      check({tag, " task_count"}, q.size(), 29);
      get_frame(0, f);
      check({tag, " frame"}, f, exp);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " err_pulses"}, err_cnt, 0);
      check({tag, " handshake"}, viol, 0);
   endtask

   localparam logic [63:0] EXP_NOM = {6'b0, 2'b10,
      16'b11_00_11_00_00_00_00_00, 2'b11,
      16'b00_00_00_11_00_00_11_00, 2'b11,
      16'b11_00_11_00_00_11_00_11, 2'b11, 2'b01};

   initial begin
      logic [63:0] f;
      int          c;
      int          nd;
      rst = 1'b1; start = 1'b0; wd_start = 1'b0; nw_start = 1'b0;
      wd_td = 1'b0; nw_td = 1'b0;
      dev = '0; mem = '0; dat = '0;
      tick(3);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset err", err, 1'b0);
      check("reset task_en", task_en, 1'b0);
      check("reset task_com", task_com, 2'b00);
      check("reset wd task_com", wd_com, 2'b00);
      rst = 1'b0;
      tick(2);

      run_frame("nominal", 5, 7'h50, 8'h12, 8'hA5, EXP_NOM);
      run_frame("k1", 1, 7'h7F, 8'hFF, 8'h00, frame(7'h7F, 8'hFF, 8'h00));
      run_frame("k20", 20, 7'h01, 8'h00, 8'hFF, frame(7'h01, 8'h00, 8'hFF));

      // Start while busy: new request and new inputs at step 10 are ignored.
      rsp_k = 3;
      clear_mon();
      dev = 7'h2A; mem = 8'h3C; dat = 8'h5A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (q.size() < 11 && c < 400) begin @(negedge clk); c++; end
      check("busy_start reached_step10", q.size() >= 11, 1'b1);
      dev = 7'h15; mem = 8'hC3; dat = 8'h0F;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", 400);
      tick(20);
      get_frame(0, f);
      check("busy_start frame", f, frame(7'h2A, 8'h3C, 8'h5A));
      check("busy_start task_count", q.size(), 29);
      check("busy_start done_pulses", done_cnt, 1);
      check("busy_start idle_after", busy, 1'b0);

      // Reset mid-frame at step 14, then a clean frame from START.
      clear_mon();
      dev = 7'h50; mem = 8'h12; dat = 8'hA5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (q.size() < 15 && c < 400) begin @(negedge clk); c++; end
      check("midrst reached_step14", q.size(), 15);
      rst = 1'b1;
      @(negedge clk);
      check("midrst task_en", task_en, 1'b0);
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      rst = 1'b0;
      tick(3);
      run_frame("after_rst", 4, 7'h33, 8'h44, 8'h55, frame(7'h33, 8'h44, 8'h55));

      // Back-to-back with start held high.
      rsp_k = 2;
      clear_mon();
      dev = 7'h0A; mem = 8'h81; dat = 8'h7E;
      start = 1'b1;
      wait_done("b2b first", 400);
      dev = 7'h65; mem = 8'h18; dat = 8'hC3;
      c = 0;
      while (!busy && c < 10) begin @(negedge clk); c++; end
      start = 1'b0;
      check("b2b restart_gap", c, 1);
      @(negedge clk);
      wait_done("b2b second", 400);
      tick(3);
      check("b2b task_count", q.size(), 58);
      get_frame(0, f);
      check("b2b frame1", f, frame(7'h0A, 8'h81, 8'h7E));
      get_frame(29, f);
      check("b2b frame2", f, frame(7'h65, 8'h18, 8'hC3));
      check("b2b done_pulses", done_cnt, 2);
      check("b2b handshake", viol, 0);

      // Watchdog abort after 16 cycles in ISSUE.
      wd_start = 1'b1;
      @(negedge clk);
      wd_start = 1'b0;
      c = 0;
      while (wd_en && c < 100) begin c++; @(negedge clk); end
      check("wd issue_cycles", c, 16);
      check("wd done", wd_done, 1'b1);
      check("wd err", wd_err, 1'b1);
      check("wd busy", wd_busy, 1'b0);
      @(negedge clk);
      check("wd done_pulse_end", wd_done, 1'b0);
      check("wd err_pulse_end", wd_err, 1'b0);
      check("wd idle_task_en", wd_en, 1'b0);

      // Watchdog disabled: stays in ISSUE well past a counter wrap.
      nw_start = 1'b1;
      @(negedge clk);
      nw_start = 1'b0;
      nd = 0;
      repeat (600) begin
         @(negedge clk);
         if (nw_done || nw_err) nd++;
      end
      check("nowd no_done", nd, 0);
      check("nowd busy", nw_busy, 1'b1);
      check("nowd task_en", nw_en, 1'b1);
      check("nowd task_com", nw_com, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
